seq_input_ctrl: RTL and testbench

SEQ_INPUT_CTRL -- requirements
Module: seq_input_ctrl

---
 rtl/seq_input_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_seq_input_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_input_ctrl.sv
// Input controller for a serial sequence detector: debounced manual bit entry,
// LSB-first pattern playback with fixed strobe spacing, and a success counter.
module seq_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key1,
    input  logic        switch0,
    input  logic        auto_mode,
    input  logic        start,
    input  logic [31:0] pattern,
    input  logic [5:0]  pat_len,
    input  logic        det_success,
    output logic        bit_valid,
    output logic        bit_data,
    output logic        busy,
    output logic        done,
    output logic [5:0]  match_count,
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_PLAY   = 2'b01,
        S_GAP    = 2'b10,
        S_FINISH = 2'b11
    } state_t;

    localparam int              RUN_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE_CYCLES);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    logic             sync1_q, sync2_q, last_q;
    logic             deb_q, deb_prev_q, armed_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             run_hit, key_rise;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] pat_q, pat_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  len_clamp;
    logic        start_acc;
    logic        bit_valid_q, bit_valid_d;
    logic        bit_data_q, bit_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        det_prev_q;
    logic [5:0]  match_q, match_d;

    // Run length of identical synchronized samples; the level follows once a run reaches the limit.
    always_comb begin
        run_d = run_q;
        if (sync2_q != last_q) begin
            run_d = RUN_W'(1);
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    assign run_hit = (run_d == RUN_MAX);
    // armed_q blocks the edge from a key that was already held through reset.
    assign key_rise = deb_q & ~deb_prev_q & armed_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            last_q     <= 1'b0;
            run_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync1_q    <= key1;
            sync2_q    <= sync1_q;
            last_q     <= sync2_q;
            run_q      <= run_d;
            deb_prev_q <= deb_q;
            if (run_hit) begin
                deb_q <= sync2_q;
            end
            if (run_hit && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign len_clamp = (pat_len > 6'd32) ? 6'd32 : pat_len;
    assign start_acc = (state_q == S_IDLE) && auto_mode && start;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        pat_d       = pat_q;
        len_d       = len_q;
        bit_valid_d = 1'b0;
        bit_data_d  = bit_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    pat_d = pattern;
                    len_d = len_clamp;
                    idx_d = 5'd0;
                    if (len_clamp != 6'd0) begin
                        state_d     = S_PLAY;
                        bit_valid_d = 1'b1;
                        bit_data_d  = pattern[0];
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (!auto_mode && key_rise) begin
                    bit_valid_d = 1'b1;
                    bit_data_d  = switch0;
                end
            end
            S_PLAY: begin
                if (!auto_mode) begin
                    state_d = S_IDLE;
                end else if ({1'b0, idx_q} == len_q - 6'd1) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    gap_d   = 8'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!auto_mode) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d     = S_PLAY;
                    bit_valid_d = 1'b1;
                    bit_data_d  = pat_q[idx_q];
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done_d = (state_d == S_FINISH);
    assign busy_d = (state_d != S_IDLE);

    // Start acceptance clears the counter and takes priority over a coincident success edge.
    always_comb begin
        match_d = match_q;
        if (start_acc) begin
            match_d = 6'd0;
        end else if (det_success && !det_prev_q && (match_q != 6'd63)) begin
            match_d = match_q + 6'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            gap_q       <= 8'd0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_prev_q  <= 1'b0;
            match_q     <= 6'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            det_prev_q  <= det_success;
            match_q     <= match_d;
        end
    end

    always_ff @(posedge clock) begin
        pat_q <= pat_d;
        len_q <= len_d;
    end

    assign bit_valid   = bit_valid_q;
    assign bit_data    = bit_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_count = match_q;
    assign ctrl_state  = state_q;

endmodule

// File: tb/tb_seq_input_ctrl.sv
// Randomized scoreboard bench for seq_input_ctrl: expected strobes/done pulses are
// queued from a cycle-level model and popped by an independent output monitor.
module tb_seq_input_ctrl;

    localparam int DEB = 4;
    localparam int GAP = 3;

    logic        clock, reset, key1, switch0, auto_mode, start, det_success;
    logic [31:0] pattern;
    logic [5:0]  pat_len;
    logic        bit_valid, bit_data, busy, done;
    logic [5:0]  match_count;
    logic [1:0]  ctrl_state;

    typedef struct {
        int         cyc;
        bit         is_done;
        bit         data;
        logic [1:0] st;
    } ev_t;

    ev_t exp_q[$];
    int  cyc       = 0;
    int  total     = 0;
    int  bad       = 0;
    int  model_cnt = 0;

    seq_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .key1(key1), .switch0(switch0),
        .auto_mode(auto_mode), .start(start), .pattern(pattern), .pat_len(pat_len),
        .det_success(det_success), .bit_valid(bit_valid), .bit_data(bit_data),
        .busy(busy), .done(done), .match_count(match_count), .ctrl_state(ctrl_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int c, input bit is_done, input bit data, input logic [1:0] st);
        ev_t e;
        e.cyc = c; e.is_done = is_done; e.data = data; e.st = st;
        exp_q.push_back(e);
    endfunction

    // Playback model: n = min(len,32) strobes every GAP+1 cycles from s, done one cycle later.
    function automatic void push_play(input int s, input logic [31:0] pat, input int len, input int max_strobes);
        int n;
        n = (len > 32) ? 32 : len;
        for (int k = 0; k < n && k < max_strobes; k++) push_ev(s + k * (GAP + 1), 1'b0, pat[k], 2'b01);
        if (max_strobes >= n) push_ev((n == 0) ? s : s + (n - 1) * (GAP + 1) + 1, 1'b1, 1'b0, 2'b11);
    endfunction

    always @(posedge clock) begin : monitor
        ev_t e;
        #2;
        if (bit_valid === 1'b1 || done === 1'b1) begin
            chk("strobe_done_excl", 32'(bit_valid & done), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: bit_valid=%0b done=%0b at cycle %0d, required none", bit_valid, done, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                chk("event_is_done", 32'(done), 32'(e.is_done));
                if (!e.is_done) chk("bit_data", 32'(bit_data), 32'(e.data));
                chk("event_ctrl_state", 32'(ctrl_state), 32'(e.st));
                chk("event_busy", 32'(busy), 32'(e.st != 2'b00));
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (6) @(negedge clock);
    endtask

    // Manual press: the strobe appears DEB+3 cycles after key1 is driven high, carrying switch0 of that edge.
    task automatic press(input int hold, input int rel, input bit expect_strobe, input int sw);
        int p;
        @(negedge clock);
        p = cyc;
        for (int i = 0; i < hold + rel; i++) begin
            if (i > 0) @(negedge clock);
            key1    = (i < hold);
            switch0 = (sw < 0) ? 1'($urandom) : 1'(sw);
            if (i == DEB + 2 && expect_strobe) push_ev(p + DEB + 3, 1'b0, switch0, 2'b00);
        end
        @(negedge clock);
        key1 = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] pat, input int len, input int max_strobes, output int s);
        @(negedge clock);
        pattern = pat;
        pat_len = 6'(len);
        start   = 1'b1;
        s       = cyc + 1;
        model_cnt = 0;
        push_play(s, pat, len, max_strobes);
        @(negedge clock);
        start   = 1'b0;
        pattern = $urandom;
        pat_len = 6'($urandom_range(0, 63));
    endtask

    task automatic det_pulse();
        det_success = 1'b1;
        if (model_cnt < 63) model_cnt++;
        @(negedge clock);
        det_success = 1'b0;
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 0);
        chk({tag, "_bit_data"}, 32'(bit_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_match_count"}, 32'(match_count), 0);
        chk({tag, "_ctrl_state"}, 32'(ctrl_state), 0);
    endtask

    initial begin
        int s;
        logic [31:0] p;
        reset = 1'b0; key1 = 1'b0; switch0 = 1'b0; auto_mode = 1'b0; start = 1'b0;
        pattern = '0; pat_len = '0; det_success = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        repeat (10) @(negedge clock);

        press(20, 15, 1'b1, 1);
        for (int i = 0; i < 6; i++) press($urandom_range(4, 14), $urandom_range(6, 10), 1'b1, -1);
        drain(20);

        for (int i = 0; i < 12; i++) begin
            key1 = ((i / 2) % 2) == 0;
            @(negedge clock);
        end
        key1 = 1'b0;
        repeat (15) @(negedge clock);

        auto_mode = 1'b1;
        press(12, 10, 1'b0, -1);
        auto_mode = 1'b0;
        start = 1'b1; pattern = 32'hFFFF_FFFF; pat_len = 6'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("manual_start_ignored_state", 32'(ctrl_state), 0);
        auto_mode = 1'b1;

        do_start(32'h0000_0155, 10, 99, s);
        drain(80);
        do_start($urandom, 0, 99, s);
        drain(10);
        do_start($urandom, 40, 99, s);
        drain(200);

        for (int i = 0; i < 5; i++) begin
            int k;
            do_start($urandom, $urandom_range(0, 40), 99, s);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) det_pulse();
            drain(200);
            chk("play_match_count", 32'(match_count), 32'(model_cnt));
        end

        p = $urandom;
        do_start(p, 12, 99, s);
        repeat (3) @(negedge clock);
        start = 1'b1; pattern = ~p; pat_len = 6'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (10) begin key1 = 1'b1; @(negedge clock); end
        key1 = 1'b0;
        repeat (8) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain(120);

        do_start($urandom, 10, 3, s);
        wait_until(s + 2 * (GAP + 1));
        auto_mode = 1'b0;
        repeat (8) @(negedge clock);
        chk("abort_ctrl_state", 32'(ctrl_state), 0);
        chk("abort_busy", 32'(busy), 0);
        drain(5);
        auto_mode = 1'b1;

        do_start($urandom, 10, 2, s);
        wait_until(s + 5);
        reset = 1'b0;
        @(negedge clock);
        chk_reset_outputs("midplay_reset");
        @(negedge clock);
        reset = 1'b1;
        model_cnt = 0;
        repeat (10) @(negedge clock);
        drain(5);

        auto_mode = 1'b0;
        key1 = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        chk("held_key_state", 32'(ctrl_state), 0);
        key1 = 1'b0;
        repeat (10) @(negedge clock);
        press(10, 10, 1'b1, -1);
        drain(20);

        for (int i = 0; i < 70; i++) begin
            det_pulse();
            if (i == 19) chk("match_count_20", 32'(match_count), 32'(model_cnt));
        end
        chk("match_count_sat_model", 32'(match_count), 32'(model_cnt));
        chk("match_count_sat", 32'(match_count), 63);

        auto_mode   = 1'b1;
        pattern     = $urandom;
        pat_len     = 6'd0;
        start       = 1'b1;
        det_success = 1'b1;
        push_ev(cyc + 1, 1'b1, 1'b0, 2'b11);
        @(negedge clock);
        start = 1'b0;
        chk("coincident_clear", 32'(match_count), 0);
        det_success = 1'b0;
        @(negedge clock);
        det_success = 1'b1;
        @(negedge clock);
        det_success = 1'b0;
        chk("count_after_clear", 32'(match_count), 1);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
